// File: rtl/biquad_pkg.sv
// Shared types, tap indices and fixed-point helpers for the multi-channel biquad cascade.
package biquad_pkg;

  localparam int N_TAPS = 5;
  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;

  // Wide working type so the helpers stay width-agnostic across instances.
  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic [1:0] {IDLE, MAC, WB, OUT} state_t;

  // Five products of DATA_W x COEF_W need 3 guard bits.
  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + 3;
  endfunction

  // Round half up, then arithmetic shift down by frac bits.
  function automatic wide_t round_shift(input wide_t v, input int frac);
    wide_t half;
    half = (frac > 0) ? (wide_t'(1) <<< (frac - 1)) : '0;
    return (v + half) >>> frac;
  endfunction

  function automatic logic sat_hit(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

  function automatic wide_t sat_clamp(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/biquad_mac.sv
// Signed multiply-accumulate for the biquad cascade, with rounded and narrowed result.
// BIQUAD_SATURATE_EN selects clamping (and the clamped flag) instead of wrap narrowing.
module biquad_mac
  import biquad_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int COEF_W    = 18,
  parameter int COEF_FRAC = 14
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     sub,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [DATA_W-1:0] data,
  output logic signed [DATA_W-1:0] y
`ifdef BIQUAD_SATURATE_EN
  ,
  output logic                     clamped
`endif
);

  localparam int ACC_W  = acc_width(DATA_W, COEF_W);
  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_p1;
  wide_t                    acc_wide;
  wide_t                    y_round;

  assign prod = PROD_W'(coef) * PROD_W'(data);

  // Stage p1: accumulator register, cleared at the start of each section.
  always_ff @(posedge clk) begin
    if (clr) begin
      acc_p1 <= '0;
    end else if (en) begin
      acc_p1 <= sub ? (acc_p1 - ACC_W'(prod)) : (acc_p1 + ACC_W'(prod));
    end
  end

  assign acc_wide = WIDE_W'(acc_p1);
  assign y_round  = round_shift(acc_wide, COEF_FRAC);

`ifdef BIQUAD_SATURATE_EN
  assign y       = DATA_W'(sat_clamp(y_round, DATA_W));
  assign clamped = sat_hit(y_round, DATA_W);
`else
  assign y       = DATA_W'(y_round);
`endif

endmodule

// File: rtl/biquad_cascade_mc.sv
// Time-multiplexed N_CH x N_STAGES Direct Form I biquad cascade on one shared MAC.
// Optional BIQUAD_SATURATE_EN adds output clamping and the sticky sat_flag port.
module biquad_cascade_mc
  import biquad_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int COEF_W    = 18,
  parameter int COEF_FRAC = 14,
  parameter int N_CH      = 4,
  parameter int N_STAGES  = 2,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int STG_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]          in_ch,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     coef_we,
  input  logic [STG_W+2:0]         coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     hist_clr
`ifdef BIQUAD_SATURATE_EN
  ,
  output logic                     sat_flag
`endif
);

  localparam logic signed [COEF_W-1:0] B0_UNITY = COEF_W'(1 << COEF_FRAC);

  state_t state_q, state_d;

  logic [STG_W-1:0]          stage_q;
  logic [2:0]                tap_q;
  logic [CH_W-1:0]           ch_q;
  logic                      discard_q;
  logic signed [DATA_W-1:0]  x_q;

  logic signed [COEF_W-1:0]  coef_q [N_STAGES][N_TAPS];
  logic signed [DATA_W-1:0]  x1_q [N_CH][N_STAGES];
  logic signed [DATA_W-1:0]  x2_q [N_CH][N_STAGES];
  logic signed [DATA_W-1:0]  y1_q [N_CH][N_STAGES];
  logic signed [DATA_W-1:0]  y2_q [N_CH][N_STAGES];

  logic                      accept;
  logic                      mac_en;
  logic                      wb;
  logic                      last_stage;
  logic                      mac_sub;
  logic signed [COEF_W-1:0]  mac_coef;
  logic signed [DATA_W-1:0]  mac_data;
  logic signed [DATA_W-1:0]  mac_y;
  logic                      mac_clamped;
  logic [STG_W-1:0]          we_stage;
  logic [2:0]                we_tap;
  logic                      we_ok;

  assign last_stage = (stage_q == STG_W'(N_STAGES - 1));
  assign we_stage   = coef_addr[STG_W+2:3];
  assign we_tap     = coef_addr[2:0];
  assign we_ok      = coef_we && in_ready &&
                      ({1'b0, we_stage} < (STG_W+1)'(N_STAGES)) && (we_tap <= TAP_A2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    mac_en   = 1'b0;
    wb       = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (tap_q == TAP_A2) state_d = WB;
      end
      WB: begin
        wb      = 1'b1;
        state_d = last_stage ? OUT : MAC;
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand select: one tap per MAC cycle from the {channel, stage} history.
  always_comb begin
    mac_coef = coef_q[stage_q][tap_q];
    mac_data = x_q;
    mac_sub  = 1'b0;
    case (tap_q)
      TAP_B1: mac_data = x1_q[ch_q][stage_q];
      TAP_B2: mac_data = x2_q[ch_q][stage_q];
      TAP_A1: begin
        mac_data = y1_q[ch_q][stage_q];
        mac_sub  = 1'b1;
      end
      TAP_A2: begin
        mac_data = y2_q[ch_q][stage_q];
        mac_sub  = 1'b1;
      end
      default: mac_data = x_q;
    endcase
  end

  biquad_mac #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC)
  ) u_mac (
    .clk     (clk),
    .clr     (accept | wb),
    .en      (mac_en),
    .sub     (mac_sub),
    .coef    (mac_coef),
    .data    (mac_data),
    .y       (mac_y)
`ifdef BIQUAD_SATURATE_EN
    ,
    .clamped (mac_clamped)
`endif
  );

`ifndef BIQUAD_SATURATE_EN
  assign mac_clamped = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q   <= '0;
      tap_q     <= '0;
      discard_q <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        stage_q   <= '0;
        tap_q     <= '0;
        discard_q <= ({1'b0, in_ch} >= (CH_W+1)'(N_CH));
      end
      if (mac_en) tap_q <= tap_q + 3'd1;
      if (wb) begin
        tap_q   <= '0;
        stage_q <= stage_q + STG_W'(1);
      end
      if (state_q == OUT && !discard_q) begin
        out_valid <= 1'b1;
        out_data  <= x_q;
        out_ch    <= ch_q;
      end
    end
  end

  // Working sample: input on accept, then each section's result feeds the next.
  always_ff @(posedge clk) begin
    if (accept) begin
      ch_q <= in_ch;
      x_q  <= in_data;
    end else if (wb) begin
      x_q  <= mac_y;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < N_STAGES; s++)
        for (int t = 0; t < N_TAPS; t++)
          coef_q[s][t] <= (t == int'(TAP_B0)) ? B0_UNITY : '0;
    end else if (we_ok) begin
      coef_q[we_stage][we_tap] <= coef_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++)
        for (int s = 0; s < N_STAGES; s++) begin
          x1_q[c][s] <= '0;
          x2_q[c][s] <= '0;
          y1_q[c][s] <= '0;
          y2_q[c][s] <= '0;
        end
    end else if (in_ready && hist_clr) begin
      for (int c = 0; c < N_CH; c++)
        for (int s = 0; s < N_STAGES; s++) begin
          x1_q[c][s] <= '0;
          x2_q[c][s] <= '0;
          y1_q[c][s] <= '0;
          y2_q[c][s] <= '0;
        end
    end else if (wb && !discard_q) begin
      x2_q[ch_q][stage_q] <= x1_q[ch_q][stage_q];
      x1_q[ch_q][stage_q] <= x_q;
      y2_q[ch_q][stage_q] <= y1_q[ch_q][stage_q];
      y1_q[ch_q][stage_q] <= mac_y;
    end
  end

`ifdef BIQUAD_SATURATE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      sat_flag <= 1'b0;
    else if (in_ready && hist_clr)  sat_flag <= 1'b0;
    else if (wb && mac_clamped)     sat_flag <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_biquad_cascade_mc.sv
// Self-checking bench for biquad_cascade_mc (DATA_W=16): vector table, corner sequences, randomized model check.
module tb_biquad_cascade_mc;

  localparam int DW  = 16;
  localparam int CW  = 18;
  localparam int CF  = 14;
  localparam int NCH = 4;
  localparam int NST = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic [1:0]           in_ch;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic [1:0]           out_ch;
  logic                 coef_we;
  logic [3:0]           coef_addr;
  logic signed [CW-1:0] coef_wdata;
  logic                 hist_clr;
`ifdef BIQUAD_SATURATE_EN
  logic                 sat_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  biquad_cascade_mc #(
    .DATA_W(DW), .COEF_W(CW), .COEF_FRAC(CF), .N_CH(NCH), .N_STAGES(NST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ch      (in_ch),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .hist_clr   (hist_clr)
`ifdef BIQUAD_SATURATE_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: per-channel, per-section difference equation on plain integers.
  longint m_coef [NST][5];
  longint m_x1 [NCH][NST];
  longint m_x2 [NCH][NST];
  longint m_y1 [NCH][NST];
  longint m_y2 [NCH][NST];
  bit     m_sat;

  function automatic void model_clear_hist();
    for (int c = 0; c < NCH; c++)
      for (int s = 0; s < NST; s++) begin
        m_x1[c][s] = 0; m_x2[c][s] = 0; m_y1[c][s] = 0; m_y2[c][s] = 0;
      end
    m_sat = 1'b0;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NST; s++)
      for (int t = 0; t < 5; t++)
        m_coef[s][t] = (t == 0) ? 16384 : 0;
    model_clear_hist();
  endfunction

  function automatic longint model_sample(input int ch, input longint x);
    longint v, acc, num, q, y;
    v = x;
    for (int s = 0; s < NST; s++) begin
      acc = m_coef[s][0] * v + m_coef[s][1] * m_x1[ch][s] + m_coef[s][2] * m_x2[ch][s]
          - m_coef[s][3] * m_y1[ch][s] - m_coef[s][4] * m_y2[ch][s];
      num = acc + 8192;
      q = num / 16384;
      if (num < 0 && (num % 16384) != 0) q = q - 1;
`ifdef BIQUAD_SATURATE_EN
      if (q > 32767) begin y = 32767; m_sat = 1'b1; end
      else if (q < -32768) begin y = -32768; m_sat = 1'b1; end
      else y = q;
`else
      y = ((q % 65536) + 65536) % 65536;
      if (y >= 32768) y = y - 65536;
`endif
      m_x2[ch][s] = m_x1[ch][s];
      m_x1[ch][s] = v;
      m_y2[ch][s] = m_y1[ch][s];
      m_y1[ch][s] = y;
      v = y;
    end
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("ready_timeout", in_ready, 1);
  endtask

  task automatic write_coef(input int st, input int tap, input longint val);
    wait_ready();
    coef_we    = 1'b1;
    coef_addr  = 4'(st * 8 + tap);
    coef_wdata = CW'(val);
    tick();
    coef_we    = 1'b0;
    m_coef[st][tap] = val;
  endtask

  task automatic clear_hist();
    wait_ready();
    hist_clr = 1'b1;
    tick();
    hist_clr = 1'b0;
    model_clear_hist();
  endtask

  // One transaction; optional same-cycle clear/write, optional ignored write while busy.
  task automatic send(input int ch, input longint x, input bit with_clr, input bit with_we,
                      input int we_st, input int we_tap, input longint we_val,
                      input bit busy_we, output longint got);
    longint exp;
    int lat;
    wait_ready();
    if (with_clr) model_clear_hist();
    if (with_we) m_coef[we_st][we_tap] = we_val;
    exp = model_sample(ch, x);
    in_valid   = 1'b1;
    in_data    = DW'(x);
    in_ch      = 2'(ch);
    hist_clr   = with_clr;
    coef_we    = with_we;
    coef_addr  = 4'(we_st * 8 + we_tap);
    coef_wdata = CW'(we_val);
    tick();
    in_valid = 1'b0;
    hist_clr = 1'b0;
    coef_we  = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (busy_we && lat == 3) begin
        check("busy_in_ready", in_ready, 0);
        coef_we    = 1'b1;
        coef_addr  = 4'd0;
        coef_wdata = '0;
        hist_clr   = 1'b1;
      end else begin
        coef_we  = 1'b0;
        hist_clr = 1'b0;
      end
      tick();
      lat++;
    end
    coef_we  = 1'b0;
    hist_clr = 1'b0;
    check("latency", lat, 13);
    check("out_data", out_data, exp);
    check("out_ch", out_ch, ch);
    got = out_data;
    tick();
    check("out_valid_pulse", out_valid, 0);
`ifdef BIQUAD_SATURATE_EN
    check("sat_flag", sat_flag, m_sat);
`endif
  endtask

  typedef struct {
    int     ch;
    longint x;
    longint exp;
  } vec_t;

  task automatic run_random();
    longint got, x;
    int ch;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(7) == 0) begin
        for (int s = 0; s < NST; s++) begin
          write_coef(s, 0, longint'($urandom_range(32767)) - 16384);
          write_coef(s, 1, longint'($urandom_range(32767)) - 16384);
          write_coef(s, 2, longint'($urandom_range(32767)) - 16384);
          write_coef(s, 3, longint'($urandom_range(8191)) - 4096);
          write_coef(s, 4, longint'($urandom_range(8191)) - 4096);
        end
      end
      ch = int'($urandom_range(NCH - 1));
      x  = longint'($urandom_range(40000)) - 20000;
      send(ch, x, ($urandom_range(9) == 0), 1'b0, 0, 0, 0, 1'b0, got);
    end
  endtask

  initial begin
    vec_t   tbl [10];
    longint got;
    int     ov_seen;

    tbl[0] = '{1, 4000, 1000};
    tbl[1] = '{1, 0,    2000};
    tbl[2] = '{1, 0,    1000};
    tbl[3] = '{1, 0,    0};
    tbl[4] = '{2, 4000, 1000};
    tbl[5] = '{3, 0,    0};
    tbl[6] = '{3, 0,    0};
    tbl[7] = '{2, 0,    2000};
    tbl[8] = '{2, 0,    1000};
    tbl[9] = '{3, 0,    0};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ch = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; hist_clr = 1'b0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
`ifdef BIQUAD_SATURATE_EN
    check("rst_sat_flag", sat_flag, 0);
`endif

    send(0, 1000, 1'b0, 1'b0, 0, 0, 0, 1'b0, got);
    check("passthrough", got, 1000);

    write_coef(0, 0, 4096);
    write_coef(0, 1, 8192);
    write_coef(0, 2, 4096);
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].ch, tbl[i].x, 1'b0, 1'b0, 0, 0, 0, 1'b0, got);
      check($sformatf("tbl%0d", i), got, tbl[i].exp);
    end

    // Busy coef_we/hist_clr must be dropped; next sample still uses b0=4096 and ch0 history.
    send(0, 500, 1'b0, 1'b0, 0, 0, 0, 1'b1, got);
    send(0, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0, got);
    check("busy_write_ignored", got, 500);

    send(1, 4000, 1'b0, 1'b0, 0, 0, 0, 1'b0, got);
    clear_hist();
    send(1, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0, got);
    check("clr_tail_gone", got, 0);

    send(2, 4000, 1'b0, 1'b1, 0, 0, 8192, 1'b0, got);
    check("we_with_valid", got, 2000);
    send(2, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0, got);
    check("clr_with_valid", got, 0);

    write_coef(0, 0, 32768);
    write_coef(0, 1, 0);
    write_coef(0, 2, 0);
    clear_hist();
    send(0, 20000, 1'b0, 1'b0, 0, 0, 0, 1'b0, got);
`ifdef BIQUAD_SATURATE_EN
    check("sat_out", got, 32767);
    check("sat_flag_set", sat_flag, 1);
    clear_hist();
    check("sat_flag_clr", sat_flag, 0);
`else
    check("wrap_out", got, -25536);
`endif

    // Abort mid-computation with reset.
    wait_ready();
    in_valid = 1'b1; in_data = DW'(777); in_ch = 2'd0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    tick();
    reset = 1'b0;
    model_reset();
    ov_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) ov_seen++;
      tick();
    end
    check("abort_no_out", ov_seen, 0);
    check("abort_ready", in_ready, 1);
    write_coef(0, 1, 16384);
    send(0, 1234, 1'b0, 1'b0, 0, 0, 0, 1'b0, got);
    check("abort_hist_zero", got, 1234);

    run_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
